// File: rtl/valtrain_pkg.sv
// Shared types and defaults for the mainband valid-lane training sequencer.
package valtrain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME,
    ST_SETTLE,
    ST_BURST,
    ST_WAIT_RES,
    ST_EVAL,
    ST_FINISH
  } state_t;

  localparam int DEF_NUM_CODES  = 16;
  localparam int DEF_ERR_THRESH = 0;

  // States that count as an active sweep (busy, abortable)
  function automatic logic is_sweep_state(input state_t s);
    return (s == ST_SETTLE) || (s == ST_BURST) || (s == ST_WAIT_RES) || (s == ST_EVAL);
  endfunction

endpackage

// File: rtl/valtrain_window_tracker.sv
// Tracks the current and best contiguous passing window of sampling codes
// and exposes the post-update best length and window centre.
module valtrain_window_tracker #(
  parameter int CODE_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_update,
  input  logic              i_pass,
  input  logic [CODE_W-1:0] i_code,
  output logic [CODE_W:0]   o_best_len_nxt,
  output logic [CODE_W-1:0] o_centre_nxt
);

  logic [CODE_W-1:0] cur_start;
  logic [CODE_W:0]   cur_len;
  logic [CODE_W-1:0] best_start;
  logic [CODE_W:0]   best_len;

  logic [CODE_W-1:0] cur_start_upd;
  logic [CODE_W:0]   cur_len_upd;
  logic [CODE_W-1:0] best_start_upd;
  logic [CODE_W:0]   best_len_upd;
  logic [CODE_W:0]   len_m1;

  // Strict greater-than keeps the lower-coded window on a tie
  always_comb begin
    cur_len_upd    = '0;
    cur_start_upd  = cur_start;
    best_start_upd = best_start;
    best_len_upd   = best_len;
    if (i_pass) begin
      cur_len_upd = cur_len + (CODE_W+1)'(1);
      if (cur_len == '0) begin
        cur_start_upd = i_code;
      end
    end
    if (cur_len_upd > best_len) begin
      best_start_upd = cur_start_upd;
      best_len_upd   = cur_len_upd;
    end
    len_m1         = best_len_upd - (CODE_W+1)'(1);
    o_best_len_nxt = best_len_upd;
    o_centre_nxt   = best_start_upd + CODE_W'(len_m1 >> 1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (i_clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (i_update) begin
      cur_start  <= cur_start_upd;
      cur_len    <= cur_len_upd;
      best_start <= best_start_upd;
      best_len   <= best_len_upd;
    end
  end

endmodule

// File: rtl/valtrain_sweep_sequencer.sv
// Valid-lane training sequencer: sweeps the RX valid sampling code, bursts the
// valid pattern per code, and programs the centre of the widest passing window.
module valtrain_sweep_sequencer
  import valtrain_pkg::*;
#(
  parameter int NUM_CODES   = DEF_NUM_CODES,
  parameter int CODE_W      = 4,
  parameter int ERR_W       = 8,
  parameter int ERR_THRESH  = DEF_ERR_THRESH,
  parameter int SETTLE_CYC  = 8,
  parameter int RES_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_frame_req,
  input  logic              i_pattern_done,
  input  logic              i_err_valid,
  input  logic [ERR_W-1:0]  i_err_cnt,
  output logic              o_valid_pattern_enable,
  output logic              o_valid_frame_enable,
  output logic [CODE_W-1:0] o_code,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [CODE_W:0]   o_win_len
);

  localparam int TMR_MAX = (RES_TIMEOUT > SETTLE_CYC) ? RES_TIMEOUT : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]  RES_LAST    = TMR_W'(RES_TIMEOUT - 1);
  localparam logic [CODE_W-1:0] LAST_CODE   = CODE_W'(NUM_CODES - 1);
  localparam logic [ERR_W-1:0]  THRESH      = ERR_W'(ERR_THRESH);

  state_t            state;
  state_t            next_state;
  logic [TMR_W-1:0]  timer;
  logic              res_pass;
  logic              abort_go;
  logic              win_clear;
  logic              win_update;
  logic [CODE_W:0]   best_len_nxt;
  logic [CODE_W-1:0] centre_nxt;

  assign abort_go   = i_abort && is_sweep_state(state);
  assign win_clear  = (state == ST_IDLE) && i_start;
  assign win_update = (state == ST_EVAL);

  valtrain_window_tracker #(
    .CODE_W (CODE_W)
  ) u_window (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_clear        (win_clear),
    .i_update       (win_update),
    .i_pass         (res_pass),
    .i_code         (o_code),
    .o_best_len_nxt (best_len_nxt),
    .o_centre_nxt   (centre_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort overrides every other transition out of a sweep state
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          next_state = ST_SETTLE;
        end else if (i_frame_req) begin
          next_state = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (!i_frame_req) begin
          next_state = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (timer == SETTLE_LAST) begin
          next_state = ST_BURST;
        end
      end
      ST_BURST: begin
        if (i_pattern_done) begin
          next_state = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        if (i_err_valid || (timer == RES_LAST)) begin
          next_state = ST_EVAL;
        end
      end
      ST_EVAL: begin
        next_state = (o_code == LAST_CODE) ? ST_FINISH : ST_SETTLE;
      end
      ST_FINISH: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    if (abort_go) begin
      next_state = ST_IDLE;
    end
  end

  // One shared timer, restarted on every state change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer <= '0;
    end else if (next_state != state) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_pass <= 1'b0;
    end else if ((state == ST_WAIT_RES) && (next_state == ST_EVAL)) begin
      res_pass <= i_err_valid && (i_err_cnt <= THRESH);
    end
  end

  // Outputs are decoded from next_state so they line up with the state they describe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_pattern_enable <= 1'b0;
      o_valid_frame_enable   <= 1'b0;
      o_code                 <= '0;
      o_busy                 <= 1'b0;
      o_done                 <= 1'b0;
      o_pass                 <= 1'b0;
      o_win_len              <= '0;
    end else begin
      o_valid_pattern_enable <= (next_state == ST_BURST) && (state != ST_BURST);
      o_valid_frame_enable   <= (next_state == ST_FRAME);
      o_busy                 <= is_sweep_state(next_state);
      o_done                 <= (next_state == ST_FINISH);
      if (abort_go || win_clear) begin
        o_code <= '0;
      end else if ((state == ST_EVAL) && (next_state == ST_SETTLE)) begin
        o_code <= o_code + CODE_W'(1);
      end else if (next_state == ST_FINISH) begin
        o_code    <= (best_len_nxt != '0) ? centre_nxt : '0;
        o_pass    <= (best_len_nxt != '0);
        o_win_len <= best_len_nxt;
      end
    end
  end

endmodule

// File: tb/tb_valtrain_sweep_sequencer.sv
// Directed self-checking bench for valtrain_sweep_sequencer.
module tb_valtrain_sweep_sequencer;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_abort;
  logic       i_frame_req;
  logic       i_pattern_done;
  logic       i_err_valid;
  logic [7:0] i_err_cnt;
  logic       o_valid_pattern_enable;
  logic       o_valid_frame_enable;
  logic [3:0] o_code;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [4:0] o_win_len;

  int tests_run;
  int tests_failed;
  int done_cnt;
  int frame_cnt;

  valtrain_sweep_sequencer dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .i_start                (i_start),
    .i_abort                (i_abort),
    .i_frame_req            (i_frame_req),
    .i_pattern_done         (i_pattern_done),
    .i_err_valid            (i_err_valid),
    .i_err_cnt              (i_err_cnt),
    .o_valid_pattern_enable (o_valid_pattern_enable),
    .o_valid_frame_enable   (o_valid_frame_enable),
    .o_code                 (o_code),
    .o_busy                 (o_busy),
    .o_done                 (o_done),
    .o_pass                 (o_pass),
    .o_win_len              (o_win_len)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_valid_frame_enable) frame_cnt <= frame_cnt + 1;
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // to_mode: 0 normal, 1 withhold result at to_code, 2 strobe on the last timeout cycle
  task automatic run_sweep(input logic [15:0] mask, input int do_start, input int to_code,
                           input int to_mode, input int abort_code, input int exp_len,
                           input int exp_code, input int exp_pass, input int exp_to_cycles);
    int cnt;
    int done_before;
    done_before = done_cnt;
    if (do_start != 0) begin
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
    end
    for (int code = 0; code < 16; code++) begin
      cnt = 0;
      while (!o_valid_pattern_enable && cnt < 400) begin
        tick();
        cnt++;
      end
      check($sformatf("burst_seen_c%0d", code), 32'(o_valid_pattern_enable), 32'd1);
      check($sformatf("code_c%0d", code), 32'(o_code), 32'(code));
      if (to_mode == 1 && code == to_code + 1) begin
        check("timeout_latency", 32'(cnt), 32'(exp_to_cycles));
      end
      if (code == abort_code) begin
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_code", 32'(o_code), 32'd0);
        check("abort_pass_held", 32'(o_pass), 32'(exp_pass));
        repeat (20) tick();
        check("abort_no_done", 32'(done_cnt), 32'(done_before));
        check("abort_idle_no_burst", 32'(o_valid_pattern_enable), 32'd0);
        return;
      end
      tick();
      check($sformatf("burst_pulse_c%0d", code), 32'(o_valid_pattern_enable), 32'd0);
      i_pattern_done = 1'b1;
      tick();
      i_pattern_done = 1'b0;
      if (to_mode == 1 && code == to_code) begin
        // no result strobe; the sequencer must time out on its own
      end else begin
        if (to_mode == 2 && code == to_code) begin
          repeat (254) tick();
        end else begin
          tick();
        end
        i_err_valid = 1'b1;
        i_err_cnt   = mask[code] ? 8'd0 : 8'd1;
        tick();
        i_err_valid = 1'b0;
        i_err_cnt   = 8'd0;
      end
    end
    cnt = 0;
    while (!o_done && cnt < 400) begin
      tick();
      cnt++;
    end
    check("done_pulse", 32'(o_done), 32'd1);
    check("done_busy_low", 32'(o_busy), 32'd0);
    check("final_win_len", 32'(o_win_len), 32'(exp_len));
    check("final_code", 32'(o_code), 32'(exp_code));
    check("final_pass", 32'(o_pass), 32'(exp_pass));
    tick();
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("code_held", 32'(o_code), 32'(exp_code));
    check("done_count", 32'(done_cnt - done_before), 32'd1);
  endtask

  initial begin
    int frame_before;
    tests_run      = 0;
    tests_failed   = 0;
    done_cnt       = 0;
    frame_cnt      = 0;
    i_rst_n        = 1'b0;
    i_start        = 1'b0;
    i_abort        = 1'b0;
    i_frame_req    = 1'b0;
    i_pattern_done = 1'b0;
    i_err_valid    = 1'b0;
    i_err_cnt      = 8'd0;
    repeat (3) tick();
    check("rst_pattern_en", 32'(o_valid_pattern_enable), 32'd0);
    check("rst_frame_en", 32'(o_valid_frame_enable), 32'd0);
    check("rst_code", 32'(o_code), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_pass", 32'(o_pass), 32'd0);
    check("rst_win_len", 32'(o_win_len), 32'd0);
    i_rst_n = 1'b1;
    tick();

    $display("[TB] all codes pass");
    run_sweep(16'hFFFF, 1, -1, 0, -1, 16, 7, 1, 0);
    $display("[TB] window 5..9");
    run_sweep(16'h03E0, 1, -1, 0, -1, 5, 7, 1, 0);
    $display("[TB] window 3..4");
    run_sweep(16'h0018, 1, -1, 0, -1, 2, 3, 1, 0);
    $display("[TB] tied windows 1..3 and 10..12");
    run_sweep(16'h1C0E, 1, -1, 0, -1, 3, 2, 1, 0);
    $display("[TB] timeout at code 4");
    run_sweep(16'hFFFF, 1, 4, 1, -1, 11, 10, 1, 264);
    $display("[TB] result on the timeout cycle at code 4");
    run_sweep(16'hFFFF, 1, 4, 2, -1, 16, 7, 1, 0);
    $display("[TB] abort at code 6");
    run_sweep(16'hFFFF, 1, -1, 0, 6, 0, 0, 1, 0);
    run_sweep(16'h0018, 1, -1, 0, -1, 2, 3, 1, 0);

    $display("[TB] start and frame request together, all codes fail");
    frame_before = frame_cnt;
    i_start      = 1'b1;
    i_frame_req  = 1'b1;
    tick();
    i_start      = 1'b0;
    i_frame_req  = 1'b0;
    check("start_wins_busy", 32'(o_busy), 32'd1);
    check("start_wins_frame", 32'(o_valid_frame_enable), 32'd0);
    run_sweep(16'h0000, 0, -1, 0, -1, 0, 0, 0, 0);
    check("no_frame_in_sweep", 32'(frame_cnt - frame_before), 32'd0);

    $display("[TB] framing grant");
    i_frame_req = 1'b1;
    tick();
    check("frame_grant", 32'(o_valid_frame_enable), 32'd1);
    check("frame_not_busy", 32'(o_busy), 32'd0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    check("frame_ignores_start", 32'(o_busy), 32'd0);
    check("frame_grant_held", 32'(o_valid_frame_enable), 32'd1);
    i_frame_req = 1'b0;
    tick();
    check("frame_release", 32'(o_valid_frame_enable), 32'd0);
    repeat (12) tick();
    check("frame_no_sweep", 32'(o_valid_pattern_enable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
